mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths come from rv32i_types/rv32i_packet.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ctrl  input  rv32i_ctrl_packet_t  control word of the instruction in MEM (mem_read, mem_write, funct3).
REQ-005 mem_in  input  rv32i_packet_t  packet from the EX/MEM register; data.alu_out holds the effective address.
REQ-006 mem_out  output  rv32i_packet_t  packet to the MEM/WB register, mem_in with data.mem_rdata filled.
REQ-007 stall_mem  output  1  high while the pipeline must hold EX/MEM and all earlier registers.
REQ-008 dmem_address  output  32  word-aligned address {alu_out[31:2],2'b00}.
REQ-009 dmem_read / dmem_write  output  1 each  request strobes, level-held until dmem_resp.
REQ-010 dmem_mbe  output  4  byte enables for stores, 4'b1111 for loads.
REQ-011 dmem_wdata  output  32  store data, lane-shifted.
REQ-012 dmem_rdata  input  32  read data, valid only with dmem_resp.
REQ-013 dmem_resp  input  1  one-cycle completion pulse.
REQ-014 mem_misalign  output  1  one-cycle flag for a trapped misaligned access (MEM_MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-016 IDLE: mem_in.valid with mem_read or mem_write -> assert request and stall_mem same cycle, go ACCESS; otherwise pass-through, stall_mem=0, stay IDLE.
REQ-017 ACCESS: hold request, address, mbe, wdata stable; stall_mem=1; on dmem_resp latch dmem_rdata, drop request next cycle, go DONE.
REQ-018 DONE: no request, stall_mem=0, mem_out carries latched data for exactly one cycle; next state IDLE.
REQ-019 Minimum memory-op latency SHALL be 2 cycles (request in cycle 0, resp in cycle 0 -> DONE in cycle 1); each extra wait cycle adds one.
REQ-020 dmem_resp outside ACCESS SHALL be ignored.
REQ-021 Invalid packets (mem_in.valid=0) SHALL never issue requests or stall, even if mem_read/mem_write set.
REQ-022 Loads: lb/lh sign-extend, lbu/lhu zero-extend the byte/halfword selected by alu_out[1:0] (halfword uses alu_out[1]); lw returns the word.
REQ-023 Stores: sb mbe=4'b0001<<addr[1:0], wdata=rs2[7:0] replicated x4; sh mbe=4'b0011<<{addr[1],1'b0}, wdata=rs2[15:0] x2; sw mbe=4'b1111, wdata=rs2.
REQ-024 mem_rdata for non-loads SHALL be 0; all other mem_in fields pass through unchanged.
REQ-025 dmem_read and dmem_write SHALL never be high together.

Reset
REQ-026 rst SHALL force state IDLE and latched data 0 at the next edge; while rst high, dmem_read, dmem_write, stall_mem, mem_misalign SHALL be 0 and mem_out.valid 0.
REQ-027 Reset in ACCESS abandons the request; a following dmem_resp is ignored per REQ-020.

Configuration
REQ-028 MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1 or lw/sw with addr[1:0]!=0 issues no request, pulses mem_misalign one cycle, passes the packet with valid=0, no stall.
REQ-029 MEM_MISALIGN_TRAP_EN undefined: low address bits below access size are ignored (truncated), access proceeds normally.

Structure
REQ-030 mem_state_t enum and mem_rdata packet field SHALL live in rv32i_packet; load/store funct3 enums come from rv32i_types.
REQ-031 Lane extraction/extension SHALL be a combinational sub-module mem_align.

Verification
REQ-032 lw addr 0x100, resp after 3 wait cycles, rdata 0xDEADBEEF -> stall 4 cycles, mem_rdata 0xDEADBEEF in DONE.
REQ-033 lb addr 0x103, rdata 0x80FF0011 -> mem_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-034 sh addr 0x202, rs2 0x1234ABCD -> dmem_address 0x200, mbe 4'b1100, wdata 0xABCDABCD.
REQ-035 rst asserted in ACCESS, resp next cycle -> IDLE, no DONE, mem_out.valid 0.
REQ-036 Trap build: sw addr 0x301 -> no request, mem_misalign one cycle, stall 0; non-trap build: request to 0x300, mbe 4'b1111.
REQ-037 Invalid packet with mem_read=1 -> no request, stall 0.

Source files
------------

// File: rtl/rv32i_packet_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_packet
// Pipeline packet formats flowing through the RV32I stages, the control word
// seen by the MEM stage, and the MEM stage FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_packet;

  import rv32i_types::*;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } rv32i_ctrl_packet_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rs2_out;
    logic [XLEN-1:0] mem_rdata;
  } rv32i_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    rv32i_data_t     data;
  } rv32i_packet_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mem_state_t;

endpackage

// File: rtl/rv32i_types_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared RV32I base types: datapath widths, load/store funct3 encodings and a
// helper that classifies an access as misaligned for its size.
// No ports (package).
// ---------------------------------------------------------------------------
package rv32i_types;

  localparam int XLEN  = 32;
  localparam int MBE_W = XLEN / 8;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Size lives in funct3[1:0] for both loads and stores, so one check covers
  // lh/lhu/sh (halfword) and lw/sw (word).
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3[1:0])
      2'b01:   mis = offset[0];
      2'b10:   mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane logic for the MEM stage.
//   funct3      in  : load/store width and signedness
//   offset      in  : low two bits of the effective address
//   rdata       in  : raw 32-bit word returned by data memory
//   rs2         in  : store source register value
//   load_data   out : selected byte/halfword/word, sign- or zero-extended
//   store_mbe   out : byte enables for the store
//   store_wdata out : store data replicated into every lane
// ---------------------------------------------------------------------------
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  input  logic [XLEN-1:0]  rdata,
  input  logic [XLEN-1:0]  rs2,
  output logic [XLEN-1:0]  load_data,
  output logic [MBE_W-1:0] store_mbe,
  output logic [XLEN-1:0]  store_wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords only look at offset[1]; offset[0] is dropped on purpose so an
  // untrapped misaligned halfword truncates to the aligned one.
  always_comb begin
    byte_sel  = rdata[{offset, 3'b000} +: 8];
    half_sel  = rdata[{offset[1], 4'b0000} +: 16];
    load_data = rdata;
    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replicating the data lets memory pick whichever lane the enables select.
  always_comb begin
    store_mbe   = 4'b1111;
    store_wdata = rs2;
    case (funct3)
      SB: begin
        store_mbe   = 4'b0001 << offset;
        store_wdata = {4{rs2[7:0]}};
      end
      SH: begin
        store_mbe   = 4'b0011 << {offset[1], 1'b0};
        store_wdata = {2{rs2[15:0]}};
      end
      default: begin
        store_mbe   = 4'b1111;
        store_wdata = rs2;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// RV32I MEM pipeline stage. Issues a data-memory request for valid loads and
// stores, stalls the front of the pipeline until the memory responds, and
// hands the packet on with mem_rdata filled for exactly one cycle.
//   clk, rst         : clock, synchronous active-high reset
//   ctrl             : control word (mem_read, mem_write, funct3)
//   mem_in / mem_out : packet from EX/MEM, packet to MEM/WB
//   stall_mem        : hold EX/MEM and all earlier registers
//   dmem_*           : data-memory request/response interface
//   mem_misalign     : one-cycle misaligned-access trap flag
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of silently truncating the low address bits.
// ---------------------------------------------------------------------------
module mem_stage
  import rv32i_types::*;
  import rv32i_packet::*;
(
  input  logic               clk,
  input  logic               rst,
  input  rv32i_ctrl_packet_t ctrl,
  input  rv32i_packet_t      mem_in,
  output rv32i_packet_t      mem_out,
  output logic               stall_mem,
  output logic [XLEN-1:0]    dmem_address,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [MBE_W-1:0]   dmem_mbe,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_resp,
  output logic               mem_misalign
);

  mem_state_t      state_q, state_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            mem_op;
  logic            misaligned;
  logic            issue;
  logic            req;
  logic [XLEN-1:0] load_data;
  logic [MBE_W-1:0] store_mbe;
  logic [XLEN-1:0] store_wdata;

  // The raw word is latched and extracted in DONE; mem_in is still held by
  // the stall, so funct3 and the offset are the ones of this access.
  mem_align u_mem_align (
    .funct3      (ctrl.funct3),
    .offset      (mem_in.data.alu_out[1:0]),
    .rdata       (rdata_q),
    .rs2         (mem_in.data.rs2_out),
    .load_data   (load_data),
    .store_mbe   (store_mbe),
    .store_wdata (store_wdata)
  );

  always_comb begin
    mem_op = mem_in.valid & (ctrl.mem_read | ctrl.mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = mem_op & is_misaligned(ctrl.funct3, mem_in.data.alu_out[1:0]);
`else
    misaligned = 1'b0;
`endif
    issue = mem_op & ~misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // The request goes out combinationally in the IDLE issue cycle, so a
  // response in that same cycle already completes the access. A response
  // with no request on the bus is never looked at.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          if (dmem_resp) begin
            state_d = DONE;
            rdata_d = dmem_rdata;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          state_d = DONE;
          rdata_d = dmem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_out.valid is dropped while stalling so MEM/WB sees a bubble instead
  // of a duplicate; the real result appears once, in DONE.
  always_comb begin
    req                    = 1'b0;
    stall_mem              = 1'b0;
    mem_misalign           = 1'b0;
    mem_out                = mem_in;
    mem_out.data.mem_rdata = '0;
    case (state_q)
      IDLE: begin
        req           = issue;
        stall_mem     = issue;
        mem_misalign  = misaligned;
        mem_out.valid = mem_in.valid & ~issue & ~misaligned;
      end
      ACCESS: begin
        req           = 1'b1;
        stall_mem     = 1'b1;
        mem_out.valid = 1'b0;
      end
      DONE: begin
        if (ctrl.mem_read) begin
          mem_out.data.mem_rdata = load_data;
        end
      end
      default: begin
        mem_out.valid = 1'b0;
      end
    endcase
    if (rst) begin
      req           = 1'b0;
      stall_mem     = 1'b0;
      mem_misalign  = 1'b0;
      mem_out.valid = 1'b0;
    end
  end

  // Read wins if a malformed control word sets both strobes.
  always_comb begin
    dmem_read    = req & ctrl.mem_read;
    dmem_write   = req & ctrl.mem_write & ~ctrl.mem_read;
    dmem_address = {mem_in.data.alu_out[XLEN-1:2], 2'b00};
    dmem_mbe     = ctrl.mem_read ? 4'b1111 : store_mbe;
    dmem_wdata   = store_wdata;
  end

endmodule
